dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 25 ++
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared pipeline definitions for the data-memory responder:
// access size encodings, FSM state encoding and alignment helper.
package dmem_responder_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] lo
   );
      return (size == SZ_HALF && lo[0])
          || (size == SZ_WORD && lo != 2'b00)
          || (size == SZ_RSVD);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: byte-enable synchronous write,
// asynchronous read. Contents are never reset.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clock,
   input  logic                           we,
   input  logic [3:0]                     be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clock) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one request in IDLE,
// waits WAIT_CYCLES edges, performs the access and strobes a response.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signext,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int IW = $clog2(DEPTH_WORDS);

   state_t         state_q;
   state_t         state_d;
   logic [3:0]     cnt_q;
   logic           accept;
   logic           access;

   logic           wr_q;
   logic           sx_q;
   logic [1:0]     sz_q;
   logic [1:0]     lo_q;
   logic [IW-1:0]  idx_q;
   logic [31:0]    wd_q;

   logic           err_now;
   logic           mem_we;
   logic [3:0]     mem_be;
   logic [31:0]    mem_wdata;
   logic [31:0]    mem_rdata;
   logic [31:0]    lane;
   logic [31:0]    ld_data;

   logic           addr_unused;
   assign addr_unused = &{1'b0, req_addr[31:IW+2]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      busy       = 1'b1;
      resp_valid = 1'b0;
      accept     = 1'b0;
      access     = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else if (accept) begin
         cnt_q <= 4'(WAIT_CYCLES - 1);
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_q  <= 1'b0;
         sx_q  <= 1'b0;
         sz_q  <= SZ_BYTE;
         lo_q  <= 2'b00;
         idx_q <= '0;
         wd_q  <= '0;
      end else if (accept) begin
         wr_q  <= req_write;
         sx_q  <= req_signext;
         sz_q  <= req_size;
         lo_q  <= req_addr[1:0];
         idx_q <= req_addr[IW+1:2];
         wd_q  <= req_wdata;
      end
   end

   assign err_now = misaligned(sz_q, lo_q);

   // Replicate store data across lanes; byte enables pick the target.
   always_comb begin
      mem_be    = 4'b0000;
      mem_wdata = wd_q;
      unique case (sz_q)
         SZ_BYTE: begin
            mem_be    = 4'b0001 << lo_q;
            mem_wdata = {4{wd_q[7:0]}};
         end
         SZ_HALF: begin
            mem_be    = lo_q[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{wd_q[15:0]}};
         end
         SZ_WORD: mem_be = 4'b1111;
         default: mem_be = 4'b0000;
      endcase
   end

   assign mem_we = access & wr_q & ~err_now;

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clock(clock),
      .we   (mem_we),
      .be   (mem_be),
      .addr (idx_q),
      .wdata(mem_wdata),
      .rdata(mem_rdata)
   );

   assign lane = mem_rdata >> {lo_q, 3'b000};

   always_comb begin
      ld_data = 32'h0;
      unique case (sz_q)
         SZ_BYTE: ld_data = {{24{sx_q & lane[7]}}, lane[7:0]};
         SZ_HALF: ld_data = {{16{sx_q & lane[15]}}, lane[15:0]};
         SZ_WORD: ld_data = mem_rdata;
         default: ld_data = 32'h0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else if (access) begin
         resp_err   <= err_now;
         resp_rdata <= (err_now || wr_q) ? 32'h0 : ld_data;
      end
   end

endmodule
